// File: rtl/program_loader.sv
// Instruction RAM writer: parses a framed byte stream of opcode/argument pairs,
// writes them to sequential addresses and holds the CPU in reset until the checksum verifies.
module program_loader #(
    parameter int unsigned PC_WIDTH       = 8,
    parameter int unsigned OPCODE_WIDTH   = 4,
    parameter int unsigned ARGUMENT_WIDTH = 8,
    parameter int unsigned INSTR_WIDTH    = OPCODE_WIDTH + ARGUMENT_WIDTH,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter bit          BOOT_HOLD      = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   mem_we,
    output logic [PC_WIDTH-1:0]    mem_addr,
    output logic [INSTR_WIDTH-1:0] mem_wdata,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   error
);

    localparam int unsigned AddrW    = PC_WIDTH + 1;
    localparam int unsigned MaxWords = 1 << PC_WIDTH;
    localparam logic [7:0]  OpMask   = 8'((1 << OPCODE_WIDTH) - 1);

    typedef enum logic [2:0] {
        StIdle, StCount, StOp, StArg, StCsum, StDone, StErr
    } state_e;

    state_e                  state_q, state_d;
    logic [8:0]              n_q, n_d;
    logic [AddrW-1:0]        addr_q, addr_d;
    logic [7:0]              sum_q, sum_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic                    in_ready_q;
    logic                    mem_we_q, mem_we_d;
    logic [PC_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [INSTR_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic                    hold_q, hold_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic       fire;
    logic [8:0] n_in;

    assign fire = in_valid && in_ready_q;
    // COUNT of zero encodes a full 256-pair frame.
    assign n_in = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        addr_d      = addr_q;
        sum_d       = sum_q;
        opcode_d    = opcode_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hold_d      = hold_q;
        done_d      = done_q;
        error_d     = error_q;
        if (fire) begin
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (in_data == SYNC_BYTE) begin
                        state_d = StCount;
                        done_d  = 1'b0;
                        error_d = 1'b0;
                        hold_d  = 1'b1;
                    end
                end
                StCount: begin
                    n_d    = n_in;
                    sum_d  = in_data;
                    addr_d = '0;
                    if (32'(n_in) > MaxWords) begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end else begin
                        state_d = StOp;
                    end
                end
                StOp: begin
                    if ((in_data & ~OpMask) != 8'h00) begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end else begin
                        opcode_d = in_data[OPCODE_WIDTH-1:0];
                        sum_d    = sum_q + in_data;
                        state_d  = StArg;
                    end
                end
                StArg: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q[PC_WIDTH-1:0];
                    mem_wdata_d = {opcode_q, in_data[ARGUMENT_WIDTH-1:0]};
                    addr_d      = addr_q + 1'b1;
                    sum_d       = sum_q + in_data;
                    state_d     = (32'(addr_q) + 32'd1 < 32'(n_q)) ? StOp : StCsum;
                end
                StCsum: begin
                    if (in_data == sum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            n_q         <= '0;
            addr_q      <= '0;
            sum_q       <= '0;
            opcode_q    <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hold_q      <= BOOT_HOLD;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            sum_q       <= sum_d;
            opcode_q    <= opcode_d;
            in_ready_q  <= 1'b1;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
